// File: rtl/sms_ram_bank_ctrl_if.sv
// Bus bundle between the AHB slave stage (master modport) and the RAM bank controller (slave modport).
interface sms_ram_bank_ctrl_if;
  logic        ram_sel;
  logic        ram_write;
  logic [2:0]  ram_size;
  logic [16:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_idle;
  logic [31:0] ram_rdata;
  logic        size_err;

  modport master (
    output ram_sel, ram_write, ram_size, ram_addr, ram_wdata, ram_idle,
    input  ram_rdata, size_err
  );

  modport slave (
    input  ram_sel, ram_write, ram_size, ram_addr, ram_wdata, ram_idle,
    output ram_rdata, size_err
  );
endinterface

// File: rtl/sms_ram_bank_ctrl.sv
// 128 KB SRAM bank controller: byte-lane write enables, one-cycle read return, idle light-sleep FSM.
// Optional lane parity (mem_pin/mem_pout/par_err) is enabled by defining SMS_RAM_PARITY_EN.
module sms_ram_bank_ctrl #(
  parameter int unsigned IDLE_TH = 16
) (
  input  logic                i_sys_hclk,
  input  logic                i_sys_rst_b,
  sms_ram_bank_ctrl_if.slave  bus,
  output logic                mem_cen,
  output logic [3:0]          mem_wen,
  output logic [14:0]         mem_addr,
  output logic [31:0]         mem_din,
  input  logic [31:0]         mem_dout,
  output logic                mem_ls,
`ifdef SMS_RAM_PARITY_EN
  output logic [3:0]          mem_pin,
  input  logic [3:0]          mem_pout,
`endif
  output logic                par_err
);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    COUNT  = 2'd1,
    SLEEP  = 2'd2
  } sleep_state_t;

  localparam logic [7:0] IDLE_TH_CNT = 8'(IDLE_TH);

  sleep_state_t state_reg, state_next;
  logic [7:0]   cnt_reg, cnt_next;
  logic         rd_pend_reg;
  logic [31:0]  rdata_hold_reg;
  logic         size_err_reg;

  logic         size_ok;
  logic         acc_ok;
  logic         rd_req;
  logic         idle_cyc;
  logic [3:0]   lane_en;

  // Sizes 011 and above are illegal and never reach the SRAM.
  assign size_ok  = ~bus.ram_size[2] & ~(bus.ram_size[1] & bus.ram_size[0]);
  assign acc_ok   = bus.ram_sel & size_ok;
  assign rd_req   = acc_ok & ~bus.ram_write;
  assign idle_cyc = bus.ram_idle & ~bus.ram_sel;

  // Halfword lanes are chosen by addr[1] only, so a misaligned addr[0] is ignored.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_en[gi] = (bus.ram_size == 3'b010)
                       | ((bus.ram_size == 3'b001) & (bus.ram_addr[1] == LANE[1]))
                       | ((bus.ram_size == 3'b000) & (bus.ram_addr[1:0] == LANE));
  end

  assign mem_cen  = ~acc_ok;
  assign mem_wen  = (acc_ok & bus.ram_write) ? ~lane_en : 4'hF;
  assign mem_addr = bus.ram_addr[16:2];
  assign mem_din  = bus.ram_wdata;

  assign bus.ram_rdata = rd_pend_reg ? mem_dout : rdata_hold_reg;
  assign bus.size_err  = size_err_reg;

  always_ff @(posedge i_sys_hclk or negedge i_sys_rst_b) begin
    if (!i_sys_rst_b) begin
      rd_pend_reg    <= 1'b0;
      rdata_hold_reg <= 32'h0;
      size_err_reg   <= 1'b0;
    end else begin
      rd_pend_reg  <= rd_req;
      size_err_reg <= bus.ram_sel & ~size_ok;
      if (rd_pend_reg) begin
        rdata_hold_reg <= mem_dout;
      end
    end
  end

  always_ff @(posedge i_sys_hclk or negedge i_sys_rst_b) begin
    if (!i_sys_rst_b) begin
      state_reg <= ACTIVE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Any request or upstream activity drops straight back to ACTIVE.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ACTIVE: begin
        if (idle_cyc) begin
          state_next = COUNT;
          cnt_next   = 8'd1;
        end
      end
      COUNT: begin
        if (!idle_cyc) begin
          state_next = ACTIVE;
          cnt_next   = 8'd0;
        end else if (cnt_reg >= IDLE_TH_CNT) begin
          state_next = SLEEP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      SLEEP: begin
        if (!idle_cyc) begin
          state_next = ACTIVE;
          cnt_next   = 8'd0;
        end
      end
      default: begin
        state_next = ACTIVE;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Light-sleep drops in the wake cycle itself so the waking access sees an awake SRAM.
  assign mem_ls = (state_reg == SLEEP) & ~bus.ram_sel;

`ifdef SMS_RAM_PARITY_EN
  logic [3:0] rd_lanes_reg;
  logic [3:0] dout_par;

  for (genvar gi = 0; gi < 4; gi++) begin : g_par
    assign mem_pin[gi]  = ^bus.ram_wdata[8*gi +: 8];
    assign dout_par[gi] = ^mem_dout[8*gi +: 8];
  end

  always_ff @(posedge i_sys_hclk or negedge i_sys_rst_b) begin
    if (!i_sys_rst_b) begin
      rd_lanes_reg <= 4'h0;
    end else if (rd_req) begin
      rd_lanes_reg <= lane_en;
    end
  end

  assign par_err = rd_pend_reg & |(rd_lanes_reg & (dout_par ^ mem_pout));
`else
  assign par_err = 1'b0;
`endif

endmodule
